uart_rx_frame: RTL and testbench

Serial receiver that sits directly downstream of the UART transmit path: it samples the serial line, recovers 7 consecutive UART characters, and reassembles them into one 56-bit APB request/response frame. It checks parity and stop bits and times out incomplete frames. The reassembled frame is handed to the bridge core through a single-cycle valid strobe.

---
 rtl/uart_rx_frame.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_uart_rx_frame.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame.sv
// uart_rx_frame
// Receives 7 consecutive UART characters (start, 8 data LSB first, optional
// parity, stop) and reassembles them into one 56-bit frame, character 0 in
// the most significant byte. Parity and stop errors are accumulated over the
// frame. A partial frame is dropped if the line stays quiet for too long.
//
// Ports
//   CLK       system clock
//   RST       asynchronous active-low reset
//   SData_Rx  serial line, idle high, asynchronous to CLK
//   clk_rate  bit period select: 16 << clk_rate CLK cycles
//   ParEN     1 = characters carry a parity bit
//   ParType   0 = even parity, 1 = odd parity
//   RX_DATA   last complete frame, held until the next one completes
//   RX_VLD    one-cycle strobe: RX_DATA / PAR_ERR / FRM_ERR updated
//   PAR_ERR   some character of the delivered frame had a parity mismatch
//   FRM_ERR   some character of the delivered frame had a low stop bit
//   TO_ERR    one-cycle strobe: a partial frame was discarded by timeout
//   BUSY      a frame is in progress
module uart_rx_frame #(
    parameter int TO_BITS = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        SData_Rx,
    input  logic [1:0]  clk_rate,
    input  logic        ParEN,
    input  logic        ParType,
    output logic [55:0] RX_DATA,
    output logic        RX_VLD,
    output logic        PAR_ERR,
    output logic        FRM_ERR,
    output logic        TO_ERR,
    output logic        BUSY
);

    localparam int TO_W = $clog2(TO_BITS * 128 + 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PAR, ST_STOP, ST_BRK, ST_GAP
    } state_t;

    // Parity check: true when data plus received parity bit match the selected sense.
    function automatic logic par_ok(input logic [7:0] d, input logic p, input logic odd);
        return ((^d) ^ p) == odd;
    endfunction

    state_t          state_r, state_nxt_s;
    logic            sync1_r, rxs_r;
    logic [7:0]      bit_cnt_r;
    logic [2:0]      bit_idx_r;
    logic [7:0]      shreg_r;
    logic [2:0]      char_cnt_r;
    logic [47:0]     asm_r;
    logic [1:0]      rate_r;
    logic            par_en_r, par_type_r;
    logic            par_e_r, frm_e_r;
    logic [TO_W-1:0] to_cnt_r;

    logic [7:0]      bit_cyc_s, half_s;
    logic [TO_W-1:0] to_lim_s;
    logic            last_s, to_hit_s, in_char_s, in_wait_s;
    logic            start_det_s, confirm_s, bit_rst_s, sample_s, par_chk_s;
    logic            char_done_s, bad_stop_s, deliver_s, timeout_s;

    // Per-character timing derived from the configuration latched at start detect.
    assign bit_cyc_s = 8'd16 << rate_r;
    assign half_s    = (bit_cyc_s >> 1) - 8'd1;
    assign last_s    = (bit_cnt_r == bit_cyc_s - 8'd1);
    assign to_lim_s  = TO_W'(TO_BITS) << (3'd4 + {1'b0, rate_r});
    assign to_hit_s  = (to_cnt_r == to_lim_s - TO_W'(1));
    assign in_char_s = (state_r == ST_START) || (state_r == ST_DATA) ||
                       (state_r == ST_PAR)   || (state_r == ST_STOP);
    assign in_wait_s = (state_r == ST_GAP) || (state_r == ST_BRK);

    // Two-flop synchronizer for the asynchronous serial line (idles high).
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync1_r <= 1'b1;
            rxs_r   <= 1'b1;
        end else begin
            sync1_r <= SData_Rx;
            rxs_r   <= sync1_r;
        end
    end

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic and per-cycle control strobes for the datapath.
    always_comb begin
        state_nxt_s = state_r;
        start_det_s = 1'b0;
        confirm_s   = 1'b0;
        bit_rst_s   = 1'b0;
        sample_s    = 1'b0;
        par_chk_s   = 1'b0;
        char_done_s = 1'b0;
        bad_stop_s  = 1'b0;
        deliver_s   = 1'b0;
        timeout_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!rxs_r) begin
                    start_det_s = 1'b1;
                    state_nxt_s = ST_START;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_cnt_r == half_s) begin
                    bit_rst_s = 1'b1;
                    if (rxs_r) begin
                        // Glitch: resume waiting without touching the character count.
                        state_nxt_s = (char_cnt_r == 3'd0) ? ST_IDLE : ST_GAP;
                    end else begin
                        confirm_s   = 1'b1;
                        state_nxt_s = ST_DATA;
                    end
                end else begin
                    state_nxt_s = ST_START;
                end
            end
            ST_DATA: begin
                if (last_s) begin
                    bit_rst_s = 1'b1;
                    sample_s  = 1'b1;
                    if (bit_idx_r == 3'd7) begin
                        state_nxt_s = par_en_r ? ST_PAR : ST_STOP;
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_PAR: begin
                if (last_s) begin
                    bit_rst_s   = 1'b1;
                    par_chk_s   = 1'b1;
                    state_nxt_s = ST_STOP;
                end else begin
                    state_nxt_s = ST_PAR;
                end
            end
            ST_STOP: begin
                if (last_s) begin
                    bit_rst_s   = 1'b1;
                    char_done_s = 1'b1;
                    bad_stop_s  = !rxs_r;
                    deliver_s   = (char_cnt_r == 3'd6);
                    if (!rxs_r) begin
                        state_nxt_s = ST_BRK;
                    end else begin
                        state_nxt_s = (char_cnt_r == 3'd6) ? ST_IDLE : ST_GAP;
                    end
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            ST_BRK: begin
                // After a delivered frame char_cnt is 0: just wait for the line to recover.
                if (rxs_r) begin
                    state_nxt_s = (char_cnt_r == 3'd0) ? ST_IDLE : ST_GAP;
                end else if ((char_cnt_r != 3'd0) && to_hit_s) begin
                    timeout_s   = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_BRK;
                end
            end
            ST_GAP: begin
                if (!rxs_r) begin
                    start_det_s = 1'b1;
                    state_nxt_s = ST_START;
                end else if (to_hit_s) begin
                    timeout_s   = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_GAP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Bit timing, timeout counter and per-character configuration capture.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bit_cnt_r  <= 8'd0;
            to_cnt_r   <= '0;
            rate_r     <= 2'd0;
            par_en_r   <= 1'b0;
            par_type_r <= 1'b0;
        end else begin
            if (in_char_s && !bit_rst_s) begin
                bit_cnt_r <= bit_cnt_r + 8'd1;
            end else begin
                bit_cnt_r <= 8'd0;
            end
            // The timeout keeps running across BRK -> GAP; any other state restarts it.
            if (in_wait_s) begin
                to_cnt_r <= to_cnt_r + TO_W'(1);
            end else begin
                to_cnt_r <= '0;
            end
            if (start_det_s) begin
                rate_r     <= clk_rate;
                par_en_r   <= ParEN;
                par_type_r <= ParType;
            end else begin
                rate_r     <= rate_r;
                par_en_r   <= par_en_r;
                par_type_r <= par_type_r;
            end
        end
    end

    // Character shifting, frame assembly, sticky error flags and outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bit_idx_r  <= 3'd0;
            shreg_r    <= 8'd0;
            char_cnt_r <= 3'd0;
            asm_r      <= 48'd0;
            par_e_r    <= 1'b0;
            frm_e_r    <= 1'b0;
            RX_DATA    <= 56'd0;
            RX_VLD     <= 1'b0;
            PAR_ERR    <= 1'b0;
            FRM_ERR    <= 1'b0;
            TO_ERR     <= 1'b0;
            BUSY       <= 1'b0;
        end else begin
            RX_VLD <= deliver_s;
            TO_ERR <= timeout_s;

            if (confirm_s) begin
                bit_idx_r <= 3'd0;
            end else if (sample_s) begin
                bit_idx_r <= bit_idx_r + 3'd1;
            end else begin
                bit_idx_r <= bit_idx_r;
            end

            if (sample_s) begin
                shreg_r <= {rxs_r, shreg_r[7:1]};
            end else begin
                shreg_r <= shreg_r;
            end

            if (char_done_s) begin
                asm_r <= {asm_r[39:0], shreg_r};
            end else begin
                asm_r <= asm_r;
            end

            if (deliver_s || timeout_s) begin
                char_cnt_r <= 3'd0;
            end else if (char_done_s) begin
                char_cnt_r <= char_cnt_r + 3'd1;
            end else begin
                char_cnt_r <= char_cnt_r;
            end

            // Stop error of the 7th character is folded straight into FRM_ERR.
            if (deliver_s) begin
                RX_DATA <= {asm_r, shreg_r};
                PAR_ERR <= par_e_r;
                FRM_ERR <= frm_e_r | bad_stop_s;
            end else begin
                RX_DATA <= RX_DATA;
                PAR_ERR <= PAR_ERR;
                FRM_ERR <= FRM_ERR;
            end

            if (deliver_s || timeout_s) begin
                par_e_r <= 1'b0;
                frm_e_r <= 1'b0;
            end else begin
                par_e_r <= par_e_r | (par_chk_s && !par_ok(shreg_r, rxs_r, par_type_r));
                frm_e_r <= frm_e_r | (char_done_s && bad_stop_s);
            end

            // BUSY rises only on a confirmed start bit so line glitches stay invisible.
            if (deliver_s || timeout_s) begin
                BUSY <= 1'b0;
            end else if (confirm_s) begin
                BUSY <= 1'b1;
            end else begin
                BUSY <= BUSY;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: bit-bangs UART characters onto the serial
// line and checks delivered frames, error flags, timeout and reset behaviour.
module tb_uart_rx_frame;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        SData_Rx = 1'b1;
    logic [1:0]  clk_rate = 2'd0;
    logic        ParEN = 1'b0;
    logic        ParType = 1'b0;
    logic [55:0] RX_DATA;
    logic        RX_VLD, PAR_ERR, FRM_ERR, TO_ERR, BUSY;

    int checks = 0;
    int failures = 0;

    // Strobe / activity counters maintained by the monitor.
    int vld_cnt = 0;
    int to_cnt = 0;
    int both_cnt = 0;
    int busy_cyc = 0;

    uart_rx_frame #(.TO_BITS(16)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .SData_Rx (SData_Rx),
        .clk_rate (clk_rate),
        .ParEN    (ParEN),
        .ParType  (ParType),
        .RX_DATA  (RX_DATA),
        .RX_VLD   (RX_VLD),
        .PAR_ERR  (PAR_ERR),
        .FRM_ERR  (FRM_ERR),
        .TO_ERR   (TO_ERR),
        .BUSY     (BUSY)
    );

    always #5 CLK = ~CLK;

    // Count strobe cycles away from the active edge.
    always @(negedge CLK) begin
        if (RX_VLD) vld_cnt <= vld_cnt + 1;
        if (TO_ERR) to_cnt <= to_cnt + 1;
        if (RX_VLD && TO_ERR) both_cnt <= both_cnt + 1;
        if (BUSY) busy_cyc <= busy_cyc + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        int bc;
        bc = 16 << clk_rate;
        SData_Rx = v;
        repeat (bc) @(negedge CLK);
    endtask

    task automatic send_char(input logic [7:0] d, input logic flip, input logic stop_v);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (ParEN) drive_bit(((^d) ^ ParType) ^ flip);
        drive_bit(stop_v);
        SData_Rx = 1'b1;
    endtask

    // Sends the first nchar characters of f, MSB byte first.
    task automatic send_frame(input logic [55:0] f, input int nchar, input int flip_idx, input int bad_stop_idx);
        for (int c = 0; c < nchar; c++) begin
            send_char(f[55 - 8*c -: 8], (c == flip_idx), (c != bad_stop_idx));
        end
        SData_Rx = 1'b1;
    endtask

    task automatic idle_bits(input int n);
        int bc;
        bc = 16 << clk_rate;
        repeat (n * bc) @(negedge CLK);
    endtask

    task automatic check_frame(input string tag, input int vld_base, input logic [55:0] data,
                               input logic par, input logic frm);
        check({tag, "_vld_once"}, 64'(vld_cnt - vld_base), 64'd1);
        check({tag, "_data"}, {8'd0, RX_DATA}, {8'd0, data});
        check({tag, "_par_err"}, {63'd0, PAR_ERR}, {63'd0, par});
        check({tag, "_frm_err"}, {63'd0, FRM_ERR}, {63'd0, frm});
        check({tag, "_busy_low"}, {63'd0, BUSY}, 64'd0);
    endtask

    initial begin
        int vb, tb, bb;

        // Reset state.
        RST = 1'b0;
        repeat (4) @(negedge CLK);
        check("rst_data", {8'd0, RX_DATA}, 64'd0);
        check("rst_vld", {63'd0, RX_VLD}, 64'd0);
        check("rst_par", {63'd0, PAR_ERR}, 64'd0);
        check("rst_frm", {63'd0, FRM_ERR}, 64'd0);
        check("rst_to", {63'd0, TO_ERR}, 64'd0);
        check("rst_busy", {63'd0, BUSY}, 64'd0);
        RST = 1'b1;
        repeat (4) @(negedge CLK);

        // Clean frame, even parity.
        clk_rate = 2'd0; ParEN = 1'b1; ParType = 1'b0;
        vb = vld_cnt;
        send_frame(56'h0123456789ABCD, 7, -1, -1);
        idle_bits(3);
        check_frame("clean", vb, 56'h0123456789ABCD, 1'b0, 1'b0);

        // Odd parity, parity bit of character 3 flipped.
        ParType = 1'b1;
        vb = vld_cnt;
        send_frame(56'hFFFFFFFFFFFFFF, 7, 3, -1);
        idle_bits(3);
        check_frame("parity", vb, 56'hFFFFFFFFFFFFFF, 1'b1, 1'b0);

        // Stop bit of character 6 low, no parity; then a good frame.
        ParEN = 1'b0; ParType = 1'b0;
        vb = vld_cnt;
        send_frame(56'h11223344556677, 7, -1, 6);
        idle_bits(3);
        check_frame("stop_err", vb, 56'h11223344556677, 1'b0, 1'b1);
        vb = vld_cnt;
        send_frame(56'hA55AC33C0FF096, 7, -1, -1);
        idle_bits(3);
        check_frame("after_stop", vb, 56'hA55AC33C0FF096, 1'b0, 1'b0);

        // Timeout after 4 characters at 32-cycle bits.
        clk_rate = 2'd1;
        vb = vld_cnt; tb = to_cnt;
        send_frame(56'hDEADBEEF000000, 4, -1, -1);
        repeat (16 * 32 + 100) @(negedge CLK);
        check("to_pulse_once", 64'(to_cnt - tb), 64'd1);
        check("to_no_vld", 64'(vld_cnt - vb), 64'd0);
        check("to_busy_low", {63'd0, BUSY}, 64'd0);
        check("to_data_kept", {8'd0, RX_DATA}, {8'd0, 56'hA55AC33C0FF096});
        vb = vld_cnt;
        send_frame(56'h13579BDF2468AC, 7, -1, -1);
        idle_bits(3);
        check_frame("after_to", vb, 56'h13579BDF2468AC, 1'b0, 1'b0);

        // Start glitch: 5-cycle low pulse.
        clk_rate = 2'd0;
        vb = vld_cnt; tb = to_cnt; bb = busy_cyc;
        SData_Rx = 1'b0;
        repeat (5) @(negedge CLK);
        SData_Rx = 1'b1;
        repeat (60) @(negedge CLK);
        check("glitch_busy_never", 64'(busy_cyc - bb), 64'd0);
        check("glitch_no_vld", 64'(vld_cnt - vb), 64'd0);
        check("glitch_no_to", 64'(to_cnt - tb), 64'd0);
        check("glitch_data_kept", {8'd0, RX_DATA}, {8'd0, 56'h13579BDF2468AC});

        // Reset during character 2 at 128-cycle bits.
        clk_rate = 2'd3; ParEN = 1'b1; ParType = 1'b0;
        vb = vld_cnt; tb = to_cnt;
        send_frame(56'h0F1E2D3C4B5A69, 2, -1, -1);
        fork
            send_char(8'h2D, 1'b0, 1'b1);
            begin
                repeat (400) @(negedge CLK);
                check("mid_busy_before_rst", {63'd0, BUSY}, 64'd1);
                RST = 1'b0;
                #1;
                check("mid_rst_data", {8'd0, RX_DATA}, 64'd0);
                check("mid_rst_par", {63'd0, PAR_ERR}, 64'd0);
                check("mid_rst_busy", {63'd0, BUSY}, 64'd0);
                check("mid_rst_vld", {63'd0, RX_VLD}, 64'd0);
            end
        join
        repeat (10) @(negedge CLK);
        RST = 1'b1;
        repeat (10) @(negedge CLK);
        check("mid_rst_no_vld", 64'(vld_cnt - vb), 64'd0);
        check("mid_rst_no_to", 64'(to_cnt - tb), 64'd0);
        vb = vld_cnt;
        send_frame(56'h0F1E2D3C4B5A69, 7, -1, -1);
        idle_bits(3);
        check_frame("after_rst", vb, 56'h0F1E2D3C4B5A69, 1'b0, 1'b0);

        check("vld_to_never_together", 64'(both_cnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
